// File: rtl/coin_acceptor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coin_acceptor_if : sensor/control inputs and coin outputs of coin_acceptor |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface coin_acceptor_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          coin5_in;
  logic          coin10_in;
  logic          enable;
  logic          ready;
  logic [3:0]    money;
  logic          coin_valid;
  logic          rejected;
  logic [CW-1:0] fifo_count;

  modport master (
    output coin5_in, coin10_in, enable, ready,
    input  money, coin_valid, rejected, fifo_count
  );

  modport slave (
    input  coin5_in, coin10_in, enable, ready,
    output money, coin_valid, rejected, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coin_acceptor : synchronizes/debounces coin sensors, buffers accepted coins |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coin_acceptor #(
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  coin_acceptor_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_QUAL     = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  localparam logic [3:0]    CNT_LAST = 4'(DEBOUNCE - 1);
  localparam logic [3:0]    CODE5    = 4'b0101;
  localparam logic [3:0]    CODE10   = 4'b1010;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  logic [1:0]            sync5_q, sync10_q;
  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  den_q, den_d;
  logic [FIFO_DEPTH-1:0] mem_q;
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         count_q;
  logic                  gap_q;
  logic [3:0]            money_q;
  logic                  valid_q;
  logic                  rejected_q;

  logic s5, s10, mine, other;
  logic qualified, reject_now, push, pop, fifo_full;

  assign s5        = sync5_q[1];
  assign s10       = sync10_q[1];
  assign mine      = den_q ? s10 : s5;
  assign other     = den_q ? s5  : s10;
  assign fifo_full = (count_q == CNT_FULL);
  assign pop       = (count_q != '0) && bus.ready && !gap_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync5_q  <= 2'b00;
      sync10_q <= 2'b00;
    end else begin
      sync5_q  <= {sync5_q[0],  bus.coin5_in};
      sync10_q <= {sync10_q[0], bus.coin10_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      den_q   <= den_d;
    end
  end

  // den_q = 1 marks a 10-unit coin
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    den_d   = den_q;
    case (state_q)
      ST_IDLE: begin
        if (s5 ^ s10) begin
          den_d   = s10;
          cnt_d   = 4'd1;
          state_d = ST_QUAL;
        end else if (s5 && s10) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_QUAL: begin
        if (other)                  state_d = ST_WAIT_REL;
        else if (!mine)             state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_WAIT_REL;
        else                        cnt_d   = cnt_q + 4'd1;
      end
      ST_WAIT_REL: begin
        if (!s5 && !s10) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    qualified  = 1'b0;
    reject_now = 1'b0;
    case (state_q)
      ST_IDLE: reject_now = s5 && s10;
      ST_QUAL: begin
        if (other)                          reject_now = 1'b1;
        else if (mine && cnt_q == CNT_LAST) qualified  = 1'b1;
      end
      default: ;
    endcase
    // Fullness is judged before any same-cycle pop
    push = qualified && bus.enable && !fifo_full;
    if (qualified && !push) reject_now = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      gap_q      <= 1'b0;
      money_q    <= 4'd0;
      valid_q    <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= den_q;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      money_q    <= pop ? (mem_q[rd_q] ? CODE10 : CODE5) : 4'd0;
      valid_q    <= pop;
      gap_q      <= pop;
      rejected_q <= reject_now;
    end
  end

  assign bus.money      = money_q;
  assign bus.coin_valid = valid_q;
  assign bus.rejected   = rejected_q;
  assign bus.fifo_count = count_q;
endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// Testbench for coin_acceptor: cycle-level reference model plus directed coin scenarios.
module tb_coin_acceptor;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus ();

  coin_acceptor #(.DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: sensor samples seen after two edges, run length of
  // single-sensor samples, queue of buffered denominations (1 = ten).
  bit m_p5 = 0, m_s5 = 0, m_p10 = 0, m_s10 = 0;
  bit m_wait = 0, m_ten = 0, m_gap = 0;
  int m_run = 0;
  bit m_q[$];
  bit m_rej, m_qual, m_pop, m_full, m_push, m_mine, m_other, m_code;
  int e_money = 0, e_count = 0;
  bit e_valid = 0, e_rej = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_p5 = 0; m_s5 = 0; m_p10 = 0; m_s10 = 0;
      m_wait = 0; m_ten = 0; m_gap = 0; m_run = 0;
      m_q.delete();
      e_money = 0; e_count = 0; e_valid = 0; e_rej = 0;
    end else begin
      m_rej = 0; m_qual = 0; m_push = 0;
      if (m_wait) begin
        if (!m_s5 && !m_s10) m_wait = 0;
      end else if (m_run == 0) begin
        if (m_s5 && m_s10) begin m_rej = 1; m_wait = 1; end
        else if (m_s5 || m_s10) begin m_ten = m_s10; m_run = 1; end
      end else begin
        m_mine  = m_ten ? m_s10 : m_s5;
        m_other = m_ten ? m_s5  : m_s10;
        if (m_other) begin m_rej = 1; m_wait = 1; m_run = 0; end
        else if (!m_mine) m_run = 0;
        else begin
          m_run++;
          if (m_run == DEB) begin m_qual = 1; m_run = 0; m_wait = 1; end
        end
      end
      m_full = (m_q.size() == DEPTH);
      if (m_qual) begin
        if (bus.enable && !m_full) m_push = 1;
        else m_rej = 1;
      end
      m_pop = (m_q.size() > 0) && bus.ready && !m_gap;
      if (m_pop) begin
        m_code  = m_q.pop_front();
        e_money = m_code ? 10 : 5;
      end else begin
        e_money = 0;
      end
      e_valid = m_pop;
      m_gap   = m_pop;
      if (m_push) m_q.push_back(m_ten);
      e_rej   = m_rej;
      e_count = m_q.size();
      m_s5 = m_p5;   m_p5  = bus.coin5_in;
      m_s10 = m_p10; m_p10 = bus.coin10_in;
    end
  end

  int obs[$];
  int vcyc[$];
  int rej_seen = 0;
  int peak = 0;
  int first_valid = -1;

  always @(negedge clk) begin
    chk("money",      int'(bus.money),      e_money);
    chk("coin_valid", int'(bus.coin_valid), int'(e_valid));
    chk("rejected",   int'(bus.rejected),   int'(e_rej));
    chk("fifo_count", int'(bus.fifo_count), e_count);
    if (bus.coin_valid) begin
      obs.push_back(int'(bus.money));
      vcyc.push_back(cyc);
      if (first_valid < 0) first_valid = cyc;
    end
    if (bus.rejected) rej_seen++;
    if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic coin(input bit ten, input int len);
    if (ten) bus.coin10_in = 1'b1;
    else     bus.coin5_in  = 1'b1;
    tick(len);
    bus.coin5_in  = 1'b0;
    bus.coin10_in = 1'b0;
  endtask

  task automatic clear_obs();
    obs.delete();
    vcyc.delete();
    rej_seen    = 0;
    peak        = 0;
    first_valid = -1;
  endtask

  function automatic int obs_at(input int i);
    return (i < obs.size()) ? obs[i] : -1;
  endfunction

  int start;

  initial begin
    bus.coin5_in  = 1'b0;
    bus.coin10_in = 1'b0;
    bus.enable    = 1'b1;
    bus.ready     = 1'b1;
    tick(3);
    chk("rst_money", int'(bus.money), 0);
    chk("rst_count", int'(bus.fifo_count), 0);
    reset = 1'b1;
    tick(2);

    // Single 5-unit coin: valid one cycle after edge 6
    clear_obs();
    start = cyc;
    coin(0, 10);
    tick(6);
    chk("t1_latency", first_valid - start, 7);
    chk("t1_n",       obs.size(), 1);
    chk("t1_code",    obs_at(0), 5);

    // Single 10-unit coin
    clear_obs();
    coin(1, 10);
    tick(6);
    chk("t2_n",    obs.size(), 1);
    chk("t2_code", obs_at(0), 10);

    // Glitch shorter than the debounce window
    clear_obs();
    coin(1, 3);
    tick(8);
    chk("t3_n",    obs.size(), 0);
    chk("t3_rej",  rej_seen, 0);
    chk("t3_peak", peak, 0);

    // Both sensors together, then a normal coin
    clear_obs();
    bus.coin5_in  = 1'b1;
    bus.coin10_in = 1'b1;
    tick(6);
    bus.coin5_in  = 1'b0;
    bus.coin10_in = 1'b0;
    tick(6);
    chk("t4_rej", rej_seen, 1);
    chk("t4_n0",  obs.size(), 0);
    coin(0, 10);
    tick(6);
    chk("t4_n1",   obs.size(), 1);
    chk("t4_code", obs_at(0), 5);

    // Fill the buffer with ready low; fifth coin is returned
    clear_obs();
    bus.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      coin(bit'(k % 2), 8);
      tick(4);
    end
    chk("t5_peak", peak, 4);
    chk("t5_rej",  rej_seen, 1);
    chk("t5_n0",   obs.size(), 0);
    bus.ready = 1'b1;
    tick(12);
    chk("t5_n",  obs.size(), 4);
    chk("t5_c0", obs_at(0), 5);
    chk("t5_c1", obs_at(1), 10);
    chk("t5_c2", obs_at(2), 5);
    chk("t5_c3", obs_at(3), 10);
    for (int i = 1; i < vcyc.size(); i++) chk("t5_spacing", vcyc[i] - vcyc[i-1], 2);
    chk("t5_count_end", int'(bus.fifo_count), 0);

    // Disabled acceptance returns the coin; buffered coin still drains
    clear_obs();
    bus.ready = 1'b0;
    coin(0, 10);
    tick(4);
    bus.enable = 1'b0;
    coin(1, 10);
    tick(4);
    chk("t6_rej",   rej_seen, 1);
    chk("t6_count", int'(bus.fifo_count), 1);
    bus.ready = 1'b1;
    tick(6);
    chk("t6_n",    obs.size(), 1);
    chk("t6_code", obs_at(0), 5);
    chk("t6_end",  int'(bus.fifo_count), 0);
    bus.enable = 1'b1;

    // Reset during qualification with two coins buffered
    clear_obs();
    bus.ready = 1'b0;
    coin(0, 10);
    tick(4);
    coin(1, 10);
    tick(4);
    chk("t7_count", int'(bus.fifo_count), 2);
    bus.coin5_in = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    chk("t7_rst_money", int'(bus.money), 0);
    chk("t7_rst_valid", int'(bus.coin_valid), 0);
    chk("t7_rst_rej",   int'(bus.rejected), 0);
    chk("t7_rst_count", int'(bus.fifo_count), 0);
    tick(2);
    reset = 1'b1;
    tick(10);
    bus.coin5_in = 1'b0;
    tick(4);
    chk("t7_requal_count", int'(bus.fifo_count), 1);
    bus.ready = 1'b1;
    tick(6);
    chk("t7_n",    obs.size(), 1);
    chk("t7_code", obs_at(0), 5);
    chk("t7_end",  int'(bus.fifo_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
